// File: rtl/lod_enc_stream_decoder.sv
// -----------------------------------------------------------------------------
// lod_enc_stream_decoder
//
// Purpose:
//   Rebuilds a request/occupancy vector that arrives serially as a stream of
//   leading-one-detector encoded positions.
//   - Each token is a leading-zero count k, measured from the MSB. A value of
//     k < a_width sets bit (a_width-1-k).
//   - A token with k >= a_width is a null token. It sets no bit, but it is
//     still counted.
//   - Tokens are ORed into an accumulator. On the token marked last, the
//     rebuilt vector and the saturating token count are presented on a
//     buffered valid/ready output.
//
// Optional feature (macro LOD_ENC_STREAM_DECODER_DUP_CHECK_EN):
//   When the macro is defined, a sticky per-frame flag reports whether any
//   non-null token hit a bit that was already set in the frame.
//   When it is undefined, out_dup is tied to 0 and no compare logic exists.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   token valid
//   in_ready   out  block can accept a token (pure state decode)
//   in_enc     in   encoded position [addr_width]
//   in_last    in   token closes the frame
//   out_valid  out  frame result valid
//   out_ready  in   consumer accepts the result
//   out_dec    out  accumulated decoded mask [a_width]
//   out_count  out  tokens accepted in the frame, saturating [addr_width]
//   out_dup    out  duplicate-position flag (0 unless the feature is built)
// -----------------------------------------------------------------------------
module lod_enc_stream_decoder #(
  parameter int a_width    = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [addr_width-1:0] in_enc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [a_width-1:0]    out_dec,
  output logic [addr_width-1:0] out_count,
  output logic                  out_dup
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [a_width-1:0]    acc_q, acc_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [a_width-1:0]    out_dec_q, out_dec_d;
  logic [addr_width-1:0] out_count_q, out_count_d;

  logic [a_width-1:0]    onehot;
  logic [a_width-1:0]    acc_merged;
  logic [addr_width-1:0] cnt_inc;
  logic                  accept;
  logic                  last_accept;

  // One comparator per output bit.
  // A null token matches none of the comparators, so it decodes to all zeros
  // without needing a separate range check.
  genvar gi;
  generate
    for (gi = 0; gi < a_width; gi++) begin : g_dec
      localparam logic [addr_width-1:0] POS = addr_width'(a_width - 1 - gi);
      assign onehot[gi] = (in_enc == POS);
    end
  endgenerate

  assign in_ready    = (state_q == ST_ACC);
  assign accept      = in_valid & in_ready;
  assign last_accept = accept & in_last;
  assign acc_merged  = acc_q | onehot;
  // The count sticks at all-ones instead of wrapping.
  assign cnt_inc     = (cnt_q == {addr_width{1'b1}}) ? cnt_q
                                                     : cnt_q + addr_width'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_dec_d   = out_dec_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (in_last) begin
            // Hand the merged result to the output register.
            // Clear the accumulator on the same edge, so the next frame
            // starts from an empty mask.
            out_dec_d   = acc_merged;
            out_count_d = cnt_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_merged;
            cnt_d = cnt_inc;
          end
        end
      end
      ST_HOLD: begin
        // out_valid is always 1 in this state, so out_ready alone completes
        // the output handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dec   = out_dec_q;
  assign out_count = out_count_q;

`ifdef LOD_ENC_STREAM_DECODER_DUP_CHECK_EN
  logic dup_q, dup_d;
  logic out_dup_q, out_dup_d;
  logic dup_merged;

  // A null token has an all-zero onehot, so it can never register a hit.
  assign dup_merged = dup_q | (|(acc_q & onehot));

  always_comb begin
    dup_d     = dup_q;
    out_dup_d = out_dup_q;
    if (last_accept) begin
      // Include a duplicate carried by the last token itself.
      out_dup_d = dup_merged;
      dup_d     = 1'b0;
    end else if (accept) begin
      dup_d = dup_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_q     <= 1'b0;
      out_dup_q <= 1'b0;
    end else begin
      dup_q     <= dup_d;
      out_dup_q <= out_dup_d;
    end
  end

  assign out_dup = out_dup_q;
`else
  // last_accept only feeds the duplicate logic.
  // It is tied off here so the signal is not left unused.
  logic unused_last_accept;
  assign unused_last_accept = last_accept;
  assign out_dup            = 1'b0;
`endif

endmodule

// File: tb/tb_lod_enc_stream_decoder.sv
module tb_lod_enc_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_enc = 4'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_dec;
  logic [3:0] out_count;
  logic       out_dup;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;
  int frame_q[$];

`ifdef LOD_ENC_STREAM_DECODER_DUP_CHECK_EN
  localparam bit DUP_BUILT = 1'b1;
`else
  localparam bit DUP_BUILT = 1'b0;
`endif

  lod_enc_stream_decoder #(.a_width(8), .addr_width(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_enc    (in_enc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one token and waits (bounded) until it is accepted.
  // Called and returns at posedge+1.
  task automatic send_tok(input int k, input bit last);
    int waited;
    logic [31:0] kv;
    waited = 0;
    kv = k;
    in_valid = 1'b1;
    in_enc = kv[3:0];
    in_last = last;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Sends frame_q as one frame.
  // Holds out_ready low for `hold` cycles while offering junk tokens.
  // Then completes the output handshake.
  task automatic run_frame(input int hold);
    int exp_mask, exp_cnt;
    bit exp_dup;
    exp_mask = 0;
    exp_cnt = 0;
    exp_dup = 1'b0;
    foreach (frame_q[i]) begin
      if (frame_q[i] < 8) begin
        if (exp_mask[7 - frame_q[i]]) exp_dup = 1'b1;
        exp_mask = exp_mask | (1 << (7 - frame_q[i]));
      end
      exp_cnt = (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
    end
    if (!DUP_BUILT) exp_dup = 1'b0;

    out_ready = 1'b0;
    foreach (frame_q[i]) send_tok(frame_q[i], i == frame_q.size() - 1);

    chk("res_valid", {31'd0, out_valid}, 32'd1);
    chk("res_in_ready", {31'd0, in_ready}, 32'd0);
    chk("res_dec", {24'd0, out_dec}, exp_mask);
    chk("res_count", {28'd0, out_count}, exp_cnt);
    chk("res_dup", {31'd0, out_dup}, {31'd0, exp_dup});

    // Offer a token while the result is held.
    // It must not be accepted; the next frame's model result would expose
    // it if it were.
    in_valid = 1'b1;
    in_enc = 4'($urandom_range(0, 15));
    in_last = 1'($urandom_range(0, 1));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_dec", {24'd0, out_dec}, exp_mask);
      chk("hold_count", {28'd0, out_count}, exp_cnt);
      chk("hold_dup", {31'd0, out_dup}, {31'd0, exp_dup});
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    $display("frame %0d: tokens=%0d hold=%0d dec=%02h count=%0d dup=%0b",
             frame_no, frame_q.size(), hold, exp_mask[7:0], exp_cnt, exp_dup);
    frame_no++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h;

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dec", {24'd0, out_dec}, 32'd0);
    chk("rst_count", {28'd0, out_count}, 32'd0);
    chk("rst_dup", {31'd0, out_dup}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back tokens 0, 3, 7.
    frame_q = '{0, 3, 7};
    run_frame(0);
    chk("t1_dec_const", {24'd0, out_dec}, 32'h91);

    // Single null token.
    frame_q = '{8};
    run_frame(0);
    chk("t2_count_const", {28'd0, out_count}, 32'd1);

    // Result held for 5 cycles.
    frame_q = '{1, 6};
    run_frame(5);
    chk("t3_dec_const", {24'd0, out_dec}, 32'h42);

    // Duplicate position.
    frame_q = '{2, 2};
    run_frame(1);
    chk("t4_dec_const", {24'd0, out_dec}, 32'h20);

    // Reset mid-frame, then a fresh frame.
    send_tok(1, 1'b0);
    send_tok(4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_dec", {24'd0, out_dec}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame_q = '{5};
    run_frame(0);
    chk("t5_dec_const", {24'd0, out_dec}, 32'h04);

    // Reset while a result is held: outputs must clear immediately.
    frame_q = '{3};
    out_ready = 1'b0;
    send_tok(3, 1'b1);
    chk("heldrst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("heldrst_valid", {31'd0, out_valid}, 32'd0);
    chk("heldrst_dec", {24'd0, out_dec}, 32'd0);
    chk("heldrst_count", {28'd0, out_count}, 32'd0);
    chk("heldrst_dup", {31'd0, out_dup}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("heldrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Saturating count: 20 tokens of value 0.
    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back(0);
    run_frame(0);
    chk("t6_count_const", {28'd0, out_count}, 32'd15);

    // Randomized frames against the model.
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 20);
      h = $urandom_range(0, 3);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back($urandom_range(0, 15));
      run_frame(h);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lod_enc_stream_decoder.md
Name: lod_enc_stream_decoder

Overview:
- Sequential decoder for leading-one-detector encoded positions.
- Accepts a stream of encoded leading-zero counts, one token per handshake, each in the same format the leading-one encoder produces.
- Decodes each token to a one-hot bit and ORs it into an accumulated mask vector.
- On the frame's last token, presents the rebuilt vector plus token count on a buffered valid/ready output. Used to reconstruct request/occupancy vectors sent serially as encoded positions.

Parameters:
- a_width, 8: decoded vector width (>= 2).
- addr_width, 4: encoded token width and count width; must satisfy 2^(addr_width-1) >= a_width, i.e. ceil(log2(a_width))+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input token valid.
- in_ready  output  1  block can accept a token.
- in_enc  input  addr_width  encoded position, counted as leading zeros from the MSB.
- in_last  input  1  token is the last of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_dec  output  a_width  accumulated decoded mask.
- out_count  output  addr_width  tokens accepted in the frame, saturating.
- out_dup  output  1  duplicate-position flag; only meaningful with the optional feature.

Behaviour:
- Single clock; reset is asynchronous and active-low (rst_n). While rst_n is low:
  - out_valid = 0, out_dec = 0, out_count = 0, out_dup = 0.
  - Internal accumulator = 0, count = 0, state = ACC.
  - in_ready = 1 after reset is released.
- Token decode: in_enc = k with k < a_width sets bit (a_width-1-k). For example, k = 0 sets the MSB.
- Null tokens: in_enc >= a_width (the all-zero encoding) sets no bit but is still counted.
- State ACC (collecting):
  - in_ready = 1, out_valid = 0.
  - A token is accepted when in_valid & in_ready at a rising edge.
  - On accept: acc <= acc | onehot(in_enc); cnt <= sat(cnt + 1).
  - On accept with in_last = 1:
    - out_dec <= acc | onehot(in_enc) and out_count <= sat(cnt + 1).
    - out_valid <= 1; state -> HOLD.
    - acc and cnt clear to 0 in the same edge.
- State HOLD (presenting):
  - in_ready = 0, so input tokens are not accepted.
  - out_valid, out_dec, out_count and out_dup stay stable until out_valid & out_ready.
  - On that handshake: out_valid <= 0, state -> ACC. out_dec and out_count keep their last values, which are don't-care while out_valid = 0.
  - in_ready rises in the cycle after the output handshake. Maximum throughput is one frame per (tokens + 1) cycles.
- in_ready is a registered-state decode: in_ready = (state == ACC). It never depends combinationally on out_ready.
- Saturation: out_count sticks at 2^addr_width - 1 and never wraps.
- Frames have no length limit. Tokens accepted beyond a_width simply OR into the mask.
- Reset mid-frame discards the partial accumulation and any held result. The next frame starts from an empty mask.
- in_enc and in_last are ignored when in_valid = 0.
- Latency: out_valid asserts 1 cycle after the last token is accepted.

Optional Feature:
- Macro: LOD_ENC_STREAM_DECODER_DUP_CHECK_EN.
- Defined:
  - A per-frame sticky flag sets when an accepted non-null token targets a bit already set in acc.
  - The flag is transferred to out_dup together with out_dec, including a duplicate on the last token.
  - The flag clears with acc at frame end and on reset.
- Not defined: out_dup is tied to 0 and no comparison logic is built.

Test Plan (a_width = 8, addr_width = 4):
- Tokens 0, 3, 7 (last), back-to-back, out_ready = 1 -> out_valid pulses 1 cycle after token 7; out_dec = 8'b1001_0001, out_count = 3; in_ready is 0 for exactly one cycle.
- Single token 8 with last -> out_dec = 8'h00, out_count = 1, out_valid = 1.
- Frame 1, 6 (last) with out_ready held 0 for 5 cycles while in_valid = 1 -> in_ready = 0 and outputs stable (8'h42, count 2) throughout. After out_ready = 1, the next token is accepted on the following cycle.
- Tokens 2, 2 (last) -> out_dec = 8'h20, out_count = 2; out_dup = 1 with LOD_ENC_STREAM_DECODER_DUP_CHECK_EN, 0 without.
- Tokens 1, 4 accepted, then rst_n pulsed low asynchronously mid-cycle -> out_valid, out_dec, out_count and out_dup go 0 immediately. The next frame, token 5 (last), gives out_dec = 8'h04, count 1.
- 20 tokens of value 0, last on the 20th -> out_dec = 8'h80, out_count = 15 (saturated).
